// File: rtl/case_9_prod_accum.sv
// Frame accumulator for the case_9 multiplier product stream: sums LEN signed
// products into a saturating accumulator and presents the result over valid/ready.
module case_9_prod_accum #(
  parameter int PROD_WIDTH = 10,
  parameter int ACC_WIDTH  = 14,
  parameter int LEN        = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  start,
  input  logic [PROD_WIDTH-1:0] prod_din,
  input  logic                  prod_vld,
  output logic                  prod_rdy,
  output logic [ACC_WIDTH-1:0]  acc_dout,
  output logic                  acc_vld,
  input  logic                  acc_rdy,
  output logic                  busy,
  output logic                  sat_flag
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Returns {saturated, clamped_sum}; overflow shows as disagreeing top two bits
  // of the one-bit-wider sum.
  function automatic logic [ACC_WIDTH:0] sat_add(
    input logic [ACC_WIDTH-1:0]  acc,
    input logic [PROD_WIDTH-1:0] prod
  );
    logic [ACC_WIDTH:0] sum;
    logic [ACC_WIDTH:0] res;
    sum = {acc[ACC_WIDTH-1], acc}
        + {{(ACC_WIDTH + 1 - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      if (sum[ACC_WIDTH]) begin
        res = {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        res = {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else begin
      res = {1'b0, sum[ACC_WIDTH-1:0]};
    end
    return res;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_dout_q, acc_dout_d;
  logic                 acc_vld_q, acc_vld_d;
  logic                 sat_q, sat_d;
  logic [ACC_WIDTH:0]   add_s;

  // Next-state and datapath decode
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    acc_dout_d = acc_dout_q;
    acc_vld_d  = acc_vld_q;
    sat_d      = sat_q;
    add_s      = sat_add(acc_q, prod_din);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (prod_vld) begin
          acc_d = add_s[ACC_WIDTH-1:0];
          sat_d = sat_q | add_s[ACC_WIDTH];
          if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            acc_dout_d = add_s[ACC_WIDTH-1:0];
            acc_vld_d  = 1'b1;
            state_d    = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_DONE: begin
        if (acc_rdy) begin
          acc_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        acc_vld_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      acc_dout_q <= '0;
      acc_vld_q  <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      acc_dout_q <= acc_dout_d;
      acc_vld_q  <= acc_vld_d;
      sat_q      <= sat_d;
    end
  end

  assign prod_rdy = (state_q == ST_ACC);
  assign busy     = (state_q != ST_IDLE);
  assign acc_dout = acc_dout_q;
  assign acc_vld  = acc_vld_q;
  assign sat_flag = sat_q;

endmodule
